keypad_scan_ctrl: RTL and testbench

Sequencer for the 4x4 keypad matrix and its single shared debouncer.
- Scan side: drives rows one-cold, samples the synchronized columns and picks one candidate key.
- Debounce side: drives the debouncer's request and active-row/active-col selects, then consumes its high/low verdicts.
- Output: one decoded key event per debounced press, plus a held flag until debounced release.

---
 rtl/keypad_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Scan/debounce sequencer for a 4x4 keypad sharing one external debouncer.
// Rows are driven one-cold; one candidate key at a time is handed to the debouncer.
module keypad_scan_ctrl #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 16384
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scan_en,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       dbnc_req,
  output logic [3:0] dbnc_active_row,
  output logic [3:0] dbnc_active_col,
  input  logic       dbnc_high,
  input  logic       dbnc_low,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {SCAN, PRESS, HELD} state_t;

  state_t        state, state_nx;
  logic [3:0]    col_meta, col_s;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    row_nx, act_row_nx, act_col_nx, code_nx;
  logic          req_nx, valid_nx, held_nx;

  // Column 0 has priority when several columns read low.
  function automatic logic [3:0] lowest_zero(input logic [3:0] v);
    if (!v[0])      return 4'b1110;
    else if (!v[1]) return 4'b1101;
    else if (!v[2]) return 4'b1011;
    else            return 4'b0111;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] oc);
    case (oc)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    state_nx   = state;
    settle_nx  = settle_cnt;
    timer_nx   = timer;
    row_nx     = row_n;
    req_nx     = dbnc_req;
    act_row_nx = dbnc_active_row;
    act_col_nx = dbnc_active_col;
    code_nx    = key_code;
    held_nx    = key_held;
    valid_nx   = 1'b0;
    case (state)
      SCAN: begin
        if (scan_en) begin
          if (settle_cnt == SETTLE_LAST) begin
            if (col_s != 4'hf) begin
              act_col_nx = lowest_zero(col_s);
              act_row_nx = row_n;
              timer_nx   = '0;
              req_nx     = 1'b1;
              state_nx   = PRESS;
            end else begin
              row_nx    = {row_n[2:0], row_n[3]};
              settle_nx = '0;
            end
          end else begin
            settle_nx = settle_cnt + SW'(1);
          end
        end
      end
      PRESS: begin
        timer_nx = timer + TW'(1);
        if (dbnc_high) begin
          valid_nx = 1'b1;
          held_nx  = 1'b1;
          code_nx  = {idx_of(dbnc_active_row), idx_of(dbnc_active_col)};
          timer_nx = '0;
          state_nx = HELD;
        end else if (dbnc_low || timer == TIMER_LAST) begin
          // Bounce or no verdict: drop the candidate and move on to the next row.
          req_nx     = 1'b0;
          act_row_nx = 4'hf;
          act_col_nx = 4'hf;
          row_nx     = {row_n[2:0], row_n[3]};
          settle_nx  = '0;
          timer_nx   = '0;
          state_nx   = SCAN;
        end
      end
      HELD: begin
        if (dbnc_low) begin
          held_nx    = 1'b0;
          req_nx     = 1'b0;
          act_row_nx = 4'hf;
          act_col_nx = 4'hf;
          row_nx     = {row_n[2:0], row_n[3]};
          settle_nx  = '0;
          state_nx   = SCAN;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_meta        <= 4'hf;
      col_s           <= 4'hf;
      state           <= SCAN;
      settle_cnt      <= '0;
      timer           <= '0;
      row_n           <= 4'b1110;
      dbnc_req        <= 1'b0;
      dbnc_active_row <= 4'hf;
      dbnc_active_col <= 4'hf;
      key_code        <= 4'h0;
      key_valid       <= 1'b0;
      key_held        <= 1'b0;
    end else begin
      col_meta        <= col_n;
      col_s           <= col_meta;
      state           <= state_nx;
      settle_cnt      <= settle_nx;
      timer           <= timer_nx;
      row_n           <= row_nx;
      dbnc_req        <= req_nx;
      dbnc_active_row <= act_row_nx;
      dbnc_active_col <= act_col_nx;
      key_code        <= code_nx;
      key_valid       <= valid_nx;
      key_held        <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed + randomized bench for keypad_scan_ctrl with an emulated keypad
// and a behavioural model built from row/column indices.
module tb_keypad_scan_ctrl;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] col_n = 4'hf;
  logic       dbnc_high = 1'b0;
  logic       dbnc_low = 1'b0;
  logic [3:0] row_n, dbnc_active_row, dbnc_active_col, key_code;
  logic       dbnc_req, key_valid, key_held;

  int n_assert = 0;
  int n_fail = 0;

  // Emulated keypad: key_pat appears on the columns only while key_row is driven.
  int         key_row = -1;
  logic [3:0] key_pat = 4'hf;

  keypad_scan_ctrl #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .scan_en(scan_en), .col_n(col_n), .row_n(row_n),
    .dbnc_req(dbnc_req), .dbnc_active_row(dbnc_active_row),
    .dbnc_active_col(dbnc_active_col), .dbnc_high(dbnc_high), .dbnc_low(dbnc_low),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oc(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  function automatic int first_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Reference model: mode 0 = scanning, 1 = awaiting verdict, 2 = key held.
  int         m_mode = 0, m_row = 0, m_cnt = 0, m_timer = 0, m_arow = 0, m_acol = 0;
  logic [3:0] m_code = 4'h0, m_c1 = 4'hf, m_cs = 4'hf;
  logic       m_valid = 1'b0, m_held = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode <= 0; m_row <= 0; m_cnt <= 0; m_timer <= 0;
      m_code <= 4'h0; m_c1 <= 4'hf; m_cs <= 4'hf; m_valid <= 1'b0; m_held <= 1'b0;
    end else begin
      m_c1 <= col_n;
      m_cs <= m_c1;
      m_valid <= 1'b0;
      if (m_mode == 0) begin
        if (scan_en) begin
          if (m_cnt < SETTLE - 1) m_cnt <= m_cnt + 1;
          else if (m_cs != 4'hf) begin
            m_acol <= first_zero(m_cs); m_arow <= m_row; m_timer <= 0; m_mode <= 1;
          end else begin
            m_row <= (m_row + 1) % 4; m_cnt <= 0;
          end
        end
      end else if (m_mode == 1) begin
        if (dbnc_high) begin
          m_valid <= 1'b1; m_held <= 1'b1; m_mode <= 2;
          m_code <= 4'(m_arow * 4 + m_acol);
        end else if (dbnc_low || m_timer == TIMEOUT - 1) begin
          m_mode <= 0; m_row <= (m_row + 1) % 4; m_cnt <= 0;
        end else m_timer <= m_timer + 1;
      end else begin
        if (dbnc_low) begin
          m_held <= 1'b0; m_mode <= 0; m_row <= (m_row + 1) % 4; m_cnt <= 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("row_n", 32'(row_n), 32'(oc(m_row)));
    chk("dbnc_req", 32'(dbnc_req), 32'(m_mode != 0));
    chk("act_row", 32'(dbnc_active_row), 32'((m_mode != 0) ? oc(m_arow) : 4'hf));
    chk("act_col", 32'(dbnc_active_col), 32'((m_mode != 0) ? oc(m_acol) : 4'hf));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_held", 32'(key_held), 32'(m_held));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    col_n = (key_row >= 0 && row_n == oc(key_row)) ? key_pat : 4'hf;
  endtask

  task automatic wait_req(input logic want);
    for (int i = 0; i < 200 && dbnc_req !== want; i++) cyc();
    chk("wait_req", 32'(dbnc_req), 32'(want));
  endtask

  task automatic pulse_low();
    dbnc_low = 1'b1; cyc(); dbnc_low = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) cyc();
    chk("rst_row", 32'(row_n), 32'(4'b1110));
    chk("rst_req", 32'(dbnc_req), 32'(0));
    chk("rst_act", 32'({dbnc_active_row, dbnc_active_col}), 32'(8'hff));
    chk("rst_code", 32'(key_code), 32'(0));
    rstn = 1'b1; scan_en = 1'b1;

    // Idle rotation, each row held SETTLE cycles
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("scan_row", 32'(row_n), 32'(oc((k / SETTLE) % 4)));
      chk("scan_req", 32'(dbnc_req), 32'(0));
    end

    // Press row2/col1, accept, then release
    key_row = 2; key_pat = 4'b1101;
    wait_req(1'b1);
    chk("t2_act_row", 32'(dbnc_active_row), 32'(4'b1011));
    chk("t2_act_col", 32'(dbnc_active_col), 32'(4'b1101));
    repeat (2) cyc();
    dbnc_high = 1'b1; cyc(); dbnc_high = 1'b0;
    chk("t2_valid", 32'(key_valid), 32'(1));
    chk("t2_code", 32'(key_code), 32'(4'b1001));
    chk("t2_held", 32'(key_held), 32'(1));
    cyc();
    chk("t2_valid_pulse", 32'(key_valid), 32'(0));
    key_row = -1;
    repeat (3) cyc();
    pulse_low();
    chk("t3_held", 32'(key_held), 32'(0));
    chk("t3_req", 32'(dbnc_req), 32'(0));
    chk("t3_row", 32'(row_n), 32'(4'b0111));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t3_no_valid", 32'(key_valid), 32'(0));
    end

    // Bounce: low verdict before any high
    key_row = 0; key_pat = 4'b0111;
    wait_req(1'b1);
    chk("t4_act_col", 32'(dbnc_active_col), 32'(4'b0111));
    key_row = -1;
    pulse_low();
    chk("t4_req", 32'(dbnc_req), 32'(0));
    chk("t4_row", 32'(row_n), 32'(4'b1101));
    chk("t4_code", 32'(key_code), 32'(4'b1001));
    chk("t4_valid", 32'(key_valid), 32'(0));

    // Timeout without verdict
    key_row = 1; key_pat = 4'b1110;
    wait_req(1'b1);
    key_row = -1;
    n = 0;
    while (dbnc_req === 1'b1 && n < 100) begin n++; cyc(); end
    chk("t5_timeout_len", 32'(n), 32'(TIMEOUT));
    chk("t5_timeout_row", 32'(row_n), 32'(4'b1011));

    // Simultaneous high and low: high wins
    key_row = 3; key_pat = 4'b0111;
    wait_req(1'b1);
    dbnc_high = 1'b1; dbnc_low = 1'b1; cyc(); dbnc_high = 1'b0; dbnc_low = 1'b0;
    chk("t5_both_valid", 32'(key_valid), 32'(1));
    chk("t5_both_code", 32'(key_code), 32'(4'b1111));
    key_row = -1;
    pulse_low();
    chk("t5_both_rel", 32'(key_held), 32'(0));

    // Multiple columns low on row 0: column 0 wins
    key_row = 0; key_pat = 4'b1010;
    wait_req(1'b1);
    chk("t5_prio_col", 32'(dbnc_active_col), 32'(4'b1110));
    chk("t5_prio_row", 32'(dbnc_active_row), 32'(4'b1110));
    key_row = -1;
    pulse_low();

    // Async reset while held
    key_row = 1; key_pat = 4'b1011;
    wait_req(1'b1);
    dbnc_high = 1'b1; cyc(); dbnc_high = 1'b0;
    chk("t6_code", 32'(key_code), 32'(4'b0110));
    key_row = -1;
    cyc();
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_row", 32'(row_n), 32'(4'b1110));
    chk("t6_rst_req", 32'(dbnc_req), 32'(0));
    chk("t6_rst_act", 32'({dbnc_active_row, dbnc_active_col}), 32'(8'hff));
    chk("t6_rst_code", 32'(key_code), 32'(0));
    chk("t6_rst_held", 32'(key_held), 32'(0));
    check_all();
    @(negedge clk);
    rstn = 1'b1; scan_en = 1'b0;

    // Frozen scan ignores a pressed key
    key_row = 0; key_pat = 4'b1110;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("t6_frozen_row", 32'(row_n), 32'(4'b1110));
      chk("t6_frozen_req", 32'(dbnc_req), 32'(0));
    end
    key_row = -1;

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      scan_en   = ($urandom_range(0, 9) != 0);
      dbnc_high = ($urandom_range(0, 15) == 0);
      dbnc_low  = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 19) == 0) begin
        key_row = int'($urandom_range(0, 4)) - 1;
        key_pat = 4'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
